// File: rtl/dma_engine.sv
// ============================================================================
// Module   : dma_engine
// Function : Single-channel word copy engine; read-then-write through one
//            holding register, sticky done flag and interrupt output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dma_engine #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] size,
    input  logic             int_en,
    input  logic             clr_done,
    input  logic             m_grant,
    input  logic [31:0]      m_din,
    output logic             m_req,
    output logic             m_wr,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_dout,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [CNT_W-1:0] r_size;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hold;
    logic             r_done;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && (size != '0)) w_next = S_REQ;
            S_REQ:  if (m_grant) w_next = S_RD;
            S_RD:   w_next = S_CAP;
            S_CAP:  w_next = S_WR;
            S_WR:   w_next = (w_cnt_inc == r_size) ? S_FIN : S_RD;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Descriptor is latched only in IDLE so bank writes mid-transfer are harmless
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_size <= '0;
            r_cnt  <= '0;
            r_hold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src  <= src_addr;
                        r_dst  <= dst_addr;
                        r_size <= size;
                        r_cnt  <= '0;
                    end
                end
                S_CAP: r_hold <= m_din;
                S_WR: begin
                    r_src <= r_src + 32'd1;
                    r_dst <= r_dst + 32'd1;
                    r_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    // FIN takes priority so a coincident clr_done cannot lose the completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (r_state == S_FIN) begin
            r_done <= 1'b1;
        end else if ((r_state == S_IDLE) && start) begin
            r_done <= (size == '0);
        end else if (clr_done) begin
            r_done <= 1'b0;
        end
    end

    always_comb begin
        m_req  = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_dout = '0;
        case (r_state)
            S_REQ: m_req = 1'b1;
            S_RD: begin
                m_req  = 1'b1;
                m_addr = r_src;
            end
            S_CAP: m_req = 1'b1;
            S_WR: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = r_dst;
                m_dout = r_hold;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign irq  = r_done & int_en;

endmodule

`default_nettype wire

// File: tb/tb_dma_engine.sv
// ============================================================================
// Module   : tb_dma_engine
// Function : Directed self-checking bench for dma_engine.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dma_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] size = '0;
    logic        int_en = 1'b0;
    logic        clr_done = 1'b0;
    logic        m_grant = 1'b0;
    logic [31:0] m_din = '0;
    logic        m_req, m_wr, busy, done, irq;
    logic [31:0] m_addr, m_dout;

    int checks = 0;
    int errors = 0;
    int gdelay = 1;
    int gcnt = 0;
    logic granted = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    dma_engine #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .size(size), .int_en(int_en), .clr_done(clr_done),
        .m_grant(m_grant), .m_din(m_din), .m_req(m_req), .m_wr(m_wr),
        .m_addr(m_addr), .m_dout(m_dout), .busy(busy), .done(done), .irq(irq)
    );

    always #5 clk = ~clk;

    // Memory returns 0xA0 + address one cycle after the address is presented
    always @(posedge clk) m_din <= 32'hA0 + m_addr;

    // Arbiter: grant after gdelay cycles of request, held until request drops
    always @(negedge clk) begin
        assert (!(granted && m_req && !m_grant)) else $error("grant dropped mid-transfer");
        if (!m_req) begin
            m_grant = 1'b0;
            gcnt    = 0;
            granted = 1'b0;
        end else begin
            if (m_grant) granted = 1'b1;
            gcnt = gcnt + 1;
            if (gcnt >= gdelay) m_grant = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_wr) begin
            wr_addr_q.push_back(m_addr);
            wr_data_q.push_back(m_dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        src_addr = s;
        dst_addr = d;
        size     = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget && done !== 1'b1; i++) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, budget);
        end
    endtask

    task automatic check_writes(input string name, input logic [31:0] a0, input logic [31:0] d0, input int n);
        logic [31:0] ea, ed;
        checks++;
        if (wr_addr_q.size() != n) begin
            errors++;
            $display("FAIL %s_count: %0d writes, required %0d", name, wr_addr_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                ea = a0 + 32'(i);
                ed = d0 + 32'(i);
                checks++;
                if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) begin
                    errors++;
                    $display("FAIL %s_w%0d: addr=%h data=%h, required addr=%h data=%h",
                             name, i, wr_addr_q[i], wr_data_q[i], ea, ed);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({m_req, m_wr, busy, done, irq} !== 5'b0 || m_addr !== 32'h0 || m_dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b wr=%b busy=%b done=%b irq=%b addr=%h dout=%h, required all 0",
                     m_req, m_wr, busy, done, irq, m_addr, m_dout);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b req=%b, required 0 0", busy, m_req);
        end
        int_en = 1'b1;
        launch(32'h0, 32'h0, 16'd0);
        checks++;
        if (done !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_done: done=%b irq=%b, required 1 1", done, irq);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: done=%b irq=%b, required 0 0", done, irq);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic ok_req = 1'b1;
        gdelay = 2;
        int_en = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        launch(32'h10, 32'h20, 16'd3);
        for (int t = 1; t <= 13; t++) begin
            if (t <= 11 && m_req !== 1'b1) ok_req = 1'b0;
            if (t == 3) begin
                checks++;
                if (m_addr !== 32'h10 || m_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_first_read: addr=%h wr=%b, required 00000010 0", m_addr, m_wr);
                end
            end
            if (t == 5) begin
                checks++;
                if (m_wr !== 1'b1 || m_addr !== 32'h20 || m_dout !== 32'hB0) begin
                    errors++;
                    $display("FAIL basic_first_write: wr=%b addr=%h dout=%h, required 1 00000020 000000b0",
                             m_wr, m_addr, m_dout);
                end
            end
            if (t == 12) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1 || m_req !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_fin: done=%b busy=%b req=%b, required 0 1 0", done, busy, m_req);
                end
            end
            if (t == 13) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || irq !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_done: done=%b busy=%b irq=%b, required 1 0 1", done, busy, irq);
                end
            end
            if (t < 13) tick();
        end
        checks++;
        if (ok_req !== 1'b1) begin
            errors++;
            $display("FAIL basic_req_held: req held=%b, required 1", ok_req);
        end
        check_writes("basic", 32'h20, 32'hB0, 3);
        int_en = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_irq_mask: irq=%b done=%b, required 0 1", irq, done);
        end
        tick();
    endtask

    task automatic test_zero_length();
        logic saw = 1'b0;
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_clr: done=%b, required 0", done);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        launch(32'h30, 32'h40, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b req=%b, required 1 0 0", done, busy, m_req);
        end
        for (int i = 0; i < 4; i++) begin
            if (m_req !== 1'b0 || busy !== 1'b0) saw = 1'b1;
            tick();
        end
        checks++;
        if (saw !== 1'b0 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_no_bus: activity=%b writes=%0d, required 0 0", saw, wr_addr_q.size());
        end
    endtask

    task automatic test_busy_guard_and_clear();
        logic found = 1'b0;
        gdelay = 1;
        int_en = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        launch(32'h100, 32'h200, 16'd2);
        tick();
        tick();
        launch(32'h500, 32'h600, 16'd9);
        for (int i = 0; i < 30 && !found; i++) begin
            if (busy === 1'b1 && m_req === 1'b0) found = 1'b1;
            else tick();
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL guard_fin: FIN state seen=%b, required 1", found);
        end
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL guard_set_wins: done=%b busy=%b, required 1 0", done, busy);
        end
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        checks++;
        if (done !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL guard_clear: done=%b irq=%b, required 0 0", done, irq);
        end
        check_writes("guard", 32'h200, 32'h1A0, 2);
    endtask

    task automatic test_wrap();
        wr_addr_q.delete();
        wr_data_q.delete();
        launch(32'hFFFF_FFFE, 32'hFFFF_FFFF, 16'd3);
        wait_done(60);
        check_writes("wrap", 32'hFFFF_FFFF, 32'h9E, 3);
        tick();
    endtask

    task automatic test_reset_mid_op();
        logic hit = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        launch(32'h40, 32'h80, 16'd5);
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            #1;
            if (wr_addr_q.size() == 2) hit = 1'b1;
        end
        checks++;
        if (hit !== 1'b1 || m_wr !== 1'b1) begin
            errors++;
            $display("FAIL midop_reach_wr: reached=%b wr=%b, required 1 1", hit, m_wr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (m_req !== 1'b0 || m_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: req=%b wr=%b busy=%b done=%b, required 0 0 0 0",
                     m_req, m_wr, busy, done);
        end
        tick();
        reset = 1'b0;
        tick();
        wr_addr_q.delete();
        wr_data_q.delete();
        launch(32'h60, 32'h70, 16'd2);
        wait_done(40);
        check_writes("midop_fresh", 32'h70, 32'h100, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_busy_guard_and_clear();
        test_wrap();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dma_engine.md
# dma_engine

Transfer engine of the DMAC, directly downstream of the 8×32 descriptor register bank. It samples source address, destination address, word count and a start pulse from the bank outputs, and arbitrates for the shared memory bus. It then copies words one at a time, read-then-write, through a single 32-bit holding register, and reports busy/done/interrupt status back to the bank.

## Interface
- `CNT_W`, default 16: width of the word-count field (bits `[CNT_W-1:0]` of the size register).
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse, written via the control register; ignored unless `busy`=0.
- `src_addr` in 32: source word address, from descriptor register 0.
- `dst_addr` in 32: destination word address, from descriptor register 1.
- `size` in CNT_W: number of words to copy, from descriptor register 2.
- `int_en` in 1: interrupt enable, from control register bit.
- `clr_done` in 1: one-cycle pulse; clears sticky `done`.
- `m_grant` in 1: bus grant from arbiter; once given, held until `m_req` drops.
- `m_din` in 32: memory read data, valid one cycle after read address.
- `m_req` out 1: bus request.
- `m_wr` out 1: 1 = write cycle, 0 = read or idle.
- `m_addr` out 32: word address.
- `m_dout` out 32: write data.
- `busy` out 1: transfer in progress.
- `done` out 1: sticky completion flag.
- `irq` out 1: `done & int_en`, combinational.

## Operation
- Reset values: `m_req`, `m_wr`, `busy`, `done` = 0; `m_addr`, `m_dout` = 0. Internal state: FSM=IDLE, counters and holding register = 0.
- On `start` in IDLE, latch `src_addr`, `dst_addr` and `size` into internal registers. Later bank changes do not affect the running transfer.
- FSM states:
  - IDLE: `busy`=0. On `start` with `size`≠0, go to REQ. On `start` with `size`=0, set `done` and stay in IDLE; the bus is never requested.
  - REQ: `busy`=1, `m_req`=1. Wait for `m_grant`=1, then go to RD.
  - RD: drive `m_addr`=cur_src, `m_wr`=0. Go to CAP.
  - CAP: capture `m_din` into the holding register. Go to WR.
  - WR: drive `m_addr`=cur_dst, `m_dout`=holding, `m_wr`=1. Increment cur_src, cur_dst and word count. If the new count = latched size, go to FIN; otherwise go to RD.
  - FIN: `m_req`=0, `m_wr`=0, set `done`. Go to IDLE.
- `m_req` stays asserted continuously from REQ through the last WR; the bus is not released between words.
- Address arithmetic: +1 per word, modulo 2^32. 0xFFFFFFFF wraps to 0x00000000 with no error.
- `done` stays set until `clr_done` or reset. It is also cleared when a new accepted `start` launches a nonzero transfer.
- `clr_done` and FIN in the same cycle: `done` ends set (set wins).
- `start` while `busy`=1: ignored, with no effect on the latched descriptor.
- Reset mid-transfer: immediate return to IDLE. `m_req`/`m_wr` drop asynchronously. The partially copied data is left as-is.
- `m_grant` dropping during RD/CAP/WR is an arbiter protocol violation. Behaviour is unspecified; the bench flags it with an assertion.

## Timing
- `start` to `m_req` high: 1 cycle (REQ entered on the next edge).
- Grant to first read address: 1 cycle after `m_grant` is sampled high in REQ.
- Per word: 3 cycles (RD, CAP, WR). One read address cycle, one data capture, one write.
- Total cycles from `start` to `done` high: 1 + G + 3·N + 1, where G = cycles waiting in REQ (≥1) and N = size.
- `size`=0: `done` high 1 cycle after `start`. `m_req` never rises.
- `busy` deasserts in the same cycle `done` rises.
- `irq` follows `done`/`int_en` with zero added latency.

## Test plan
1. **Reset:** assert `reset` asynchronously mid-cycle → all outputs 0 immediately; FSM idle after release.
2. **Basic copy:** src=0x10, dst=0x20, size=3, grant 2 cycles after `m_req`, memory returns 0xA0+addr. Required:
   - reads at 0x10, 0x11, 0x12;
   - writes at 0x20, 0x21, 0x22 with data 0xB0, 0xB1, 0xB2;
   - `done` at cycle 1+2+9+1 = 13;
   - `irq`=1 when `int_en`=1.
3. **Zero length:** size=0, `start` → `done`=1 next cycle; `m_req` stays 0 throughout; `busy` never rises.
4. **Busy guard and clear:**
   - second `start` with different src during a transfer → ignored; addresses continue from the original descriptor;
   - `clr_done` in the FIN cycle → `done` remains 1;
   - `clr_done` one cycle later → `done`=0, `irq`=0.
5. **Wrap:** src=0xFFFFFFFE, dst=0xFFFFFFFF, size=3 → reads at FFFFFFFE, FFFFFFFF, 00000000; writes at FFFFFFFF, 00000000, 00000001.
6. **Reset mid-op:** `reset` during the second WR of a size=5 transfer → `m_req`/`m_wr`/`busy` drop at once, `done`=0. A fresh `start` then completes normally.
